dsc_sng: RTL

Deterministic stochastic number generator: the stage directly upstream of the dsc multiply core, one instance per operand.
- Converts a latched binary operand into a 2^DATA_WIDTH-bit deterministic bitstream whose ones-count equals the operand exactly.
- Supports an advance input for clock-division chaining: an inner generator's wrap drives the outer generator's adv.
- Reports period completion so the downstream core/counter can terminate the operation.

---
 rtl/dsc_pkg.sv | 27 ++
 rtl/dsc_sng.sv | 93 +++++++++
 2 files changed

// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic (dsc) datapath.
// Used by the number generators, the multiply core and their models.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sng_state_t;

    localparam int MODE_UNARY  = 0;
    localparam int MODE_BITREV = 1;
    localparam int MAX_W       = 32;

    // Reverse the low w bits of x; w must be in 1..MAX_W.
    function automatic logic [MAX_W-1:0] bitrev(
        input logic [MAX_W-1:0] x,
        input int unsigned      w
    );
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = x[MAX_W-1-i];
        end
        return r >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/dsc_sng.sv
// Deterministic stochastic number generator: emits a 2^DATA_WIDTH-bit
// stream whose ones-count equals the latched operand exactly.
module dsc_sng
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  en,
    input  logic                  adv,
    input  logic                  loop,
    input  logic [DATA_WIDTH-1:0] bin_in,
    output logic                  sn_out,
    output logic                  sn_valid,
    output logic                  wrap,
    output logic                  busy,
    output logic                  done
);

    sng_state_t            state;
    sng_state_t            state_nxt;
    logic [DATA_WIDTH-1:0] ctr;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] f_ctr;
    logic                  fire;
    logic                  last;

    assign fire = (state == RUN) && en && adv && !start;
    assign last = &ctr;

    always_comb begin
        f_ctr = ctr;
        if (MODE == MODE_BITREV) begin
            f_ctr = DATA_WIDTH'(bitrev(MAX_W'(ctr), DATA_WIDTH));
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else if (fire && last && !loop) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr      <= '0;
            value    <= '0;
            sn_out   <= 1'b0;
            sn_valid <= 1'b0;
            wrap     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            if (start) begin
                value    <= bin_in;
                ctr      <= '0;
                done     <= 1'b0;
                sn_out   <= 1'b0;
                sn_valid <= 1'b0;
                wrap     <= 1'b0;
            end else if (fire) begin
                sn_out   <= (f_ctr < value);
                sn_valid <= 1'b1;
                wrap     <= last;
                ctr      <= ctr + 1'b1;
                // a non-looping stream parks in DONE with the final bit
                if (last && !loop) begin
                    done <= 1'b1;
                end
            end else begin
                sn_out   <= 1'b0;
                sn_valid <= 1'b0;
                wrap     <= 1'b0;
            end
        end
    end

endmodule
